// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU converters.
//   rm_e       - rounding-mode encoding as seen on the rm ports
//   fclass_e   - 10-bit one-hot float class
//   i2f_st_e   - state encoding of the int-to-float FSM
//   rm_decode  - maps a raw 3-bit rm code to rm_e; unused codes fall back to RNE
package fpu_pkg;

    localparam int FP32_BIAS   = 127;
    localparam int FP32_MANT_W = 23;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    typedef enum logic [9:0] {
        FC_NEG_INF  = 10'b00_0000_0001,
        FC_NEG_NORM = 10'b00_0000_0010,
        FC_NEG_SUB  = 10'b00_0000_0100,
        FC_NEG_ZERO = 10'b00_0000_1000,
        FC_POS_ZERO = 10'b00_0001_0000,
        FC_POS_SUB  = 10'b00_0010_0000,
        FC_POS_NORM = 10'b00_0100_0000,
        FC_POS_INF  = 10'b00_1000_0000,
        FC_SNAN     = 10'b01_0000_0000,
        FC_QNAN     = 10'b10_0000_0000
    } fclass_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } i2f_st_e;

    function automatic rm_e rm_decode(input logic [2:0] code);
        case (code)
            3'b001:  return RM_RTZ;
            3'b010:  return RM_RDN;
            3'b011:  return RM_RUP;
            3'b100:  return RM_RMM;
            default: return RM_RNE;
        endcase
    endfunction

endpackage

// File: rtl/fpu_round.sv
// fpu_round: combinational mantissa rounder shared by the FPU converters.
//   sign      in   sign of the value being rounded (directed modes)
//   mant      in   23-bit truncated mantissa
//   guard     in   first bit below the mantissa LSB
//   sticky    in   OR of all bits below guard
//   rm        in   rounding mode
//   mant_rnd  out  rounded mantissa (wraps to 0 on carry)
//   carry     out  mantissa overflowed; caller bumps the exponent
//   nx        out  result is inexact
module fpu_round
    import fpu_pkg::*;
(
    input  logic                   sign,
    input  logic [FP32_MANT_W-1:0] mant,
    input  logic                   guard,
    input  logic                   sticky,
    input  rm_e                    rm,
    output logic [FP32_MANT_W-1:0] mant_rnd,
    output logic                   carry,
    output logic                   nx
);

    logic inc;

    always_comb begin
        inc = 1'b0;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (guard | sticky);
            RM_RUP:  inc = ~sign & (guard | sticky);
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | mant[0]);
        endcase
    end

    assign {carry, mant_rnd} = {1'b0, mant} + {{FP32_MANT_W{1'b0}}, inc};
    assign nx                = guard | sticky;

endmodule

// File: rtl/fpu_int2float.sv
// fpu_int2float: multi-cycle 32-bit integer to binary32 converter
// (FCVT.S.W / FCVT.S.WU). Normalises one bit per cycle, then rounds.
//   clk, rst_n            clock, async active-low reset
//   flush                 synchronous abort, returns to IDLE
//   in_valid/in_ready     request handshake (int_val, is_unsigned, rm)
//   out_valid/out_ready   result handshake (f_result, fflags)
//   f_class               one-hot class of f_result, only when the
//                         FPU_I2F_CLASS_EN macro is defined
// A conversion with lz leading zeros raises out_valid lz+2 edges after
// acceptance: out_valid is registered one cycle after the result lands
// in DONE, so the result is already stable when it is offered.
module fpu_int2float
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] int_val,
    input  logic        is_unsigned,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] f_result,
    output logic [4:0]  fflags
`ifdef FPU_I2F_CLASS_EN
    ,
    output logic [9:0]  f_class
`endif
);

    localparam logic [7:0] EXP_TOP = 8'(FP32_BIAS + 31);

    i2f_st_e     state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic        sign_q, sign_d;
    rm_e         rm_q, rm_d;
    logic [5:0]  lz_q, lz_d;
    logic [31:0] f_result_q, f_result_d;
    logic [4:0]  fflags_q, fflags_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;
`ifdef FPU_I2F_CLASS_EN
    logic [9:0]  f_class_q, f_class_d;
`endif

    logic [FP32_MANT_W-1:0] rnd_mant;
    logic                   rnd_carry;
    logic                   rnd_nx;
    logic [7:0]             exp_rnd;
    logic [31:0]            res_word;

    fpu_round u_round (
        .sign     (sign_q),
        .mant     (mag_q[30:8]),
        .guard    (mag_q[7]),
        .sticky   (|mag_q[6:0]),
        .rm       (rm_q),
        .mant_rnd (rnd_mant),
        .carry    (rnd_carry),
        .nx       (rnd_nx)
    );

    assign exp_rnd  = EXP_TOP - {2'b00, lz_q} + {7'd0, rnd_carry};
    // Zero never normalises, so it is special-cased to +0.0 here.
    assign res_word = (mag_q == 32'd0) ? 32'd0 : {sign_q, exp_rnd, rnd_mant};

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        sign_d      = sign_q;
        rm_d        = rm_q;
        lz_d        = lz_q;
        f_result_d  = f_result_q;
        fflags_d    = fflags_q;
        out_valid_d = 1'b0;
`ifdef FPU_I2F_CLASS_EN
        f_class_d   = f_class_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d  = int_val[31] & ~is_unsigned;
                    mag_d   = sign_d ? (~int_val + 32'd1) : int_val;
                    rm_d    = rm_decode(rm);
                    lz_d    = 6'd0;
                    state_d = ((mag_d == 32'd0) || mag_d[31]) ? ST_ROUND : ST_NORM;
                end
            end
            ST_NORM: begin
                mag_d = {mag_q[30:0], 1'b0};
                lz_d  = lz_q + 6'd1;
                if (mag_d[31]) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                f_result_d = res_word;
                fflags_d   = {4'b0000, (mag_q != 32'd0) & rnd_nx};
`ifdef FPU_I2F_CLASS_EN
                if (mag_q == 32'd0) begin
                    f_class_d = FC_POS_ZERO;
                end else if (sign_q) begin
                    f_class_d = FC_NEG_NORM;
                end else begin
                    f_class_d = FC_POS_NORM;
                end
`endif
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mag_q       <= 32'd0;
            sign_q      <= 1'b0;
            rm_q        <= RM_RNE;
            lz_q        <= 6'd0;
            f_result_q  <= 32'd0;
            fflags_q    <= 5'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef FPU_I2F_CLASS_EN
            f_class_q   <= 10'd0;
`endif
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            sign_q      <= sign_d;
            rm_q        <= rm_d;
            lz_q        <= lz_d;
            f_result_q  <= f_result_d;
            fflags_q    <= fflags_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef FPU_I2F_CLASS_EN
            f_class_q   <= f_class_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign f_result  = f_result_q;
    assign fflags    = fflags_q;
`ifdef FPU_I2F_CLASS_EN
    assign f_class   = f_class_q;
`endif

endmodule

// File: tb/tb_fpu_int2float.sv
// tb_fpu_int2float: directed-vector bench for fpu_int2float.
// Builds with or without FPU_I2F_CLASS_EN; class checks only in the former.
module tb_fpu_int2float;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] int_val;
    logic        is_unsigned;
    logic [2:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] f_result;
    logic [4:0]  fflags;
`ifdef FPU_I2F_CLASS_EN
    logic [9:0]  f_class;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    fpu_int2float dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .int_val     (int_val),
        .is_unsigned (is_unsigned),
        .rm          (rm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .f_result    (f_result),
        .fflags      (fflags)
`ifdef FPU_I2F_CLASS_EN
        ,
        .f_class     (f_class)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] v;
        logic        u;
        logic [2:0]  r;
        logic [31:0] e;
        logic        nx;
        logic [5:0]  lat;
    } vec_t;

    // Present a request and return once it has been accepted; ir1 is
    // in_ready sampled just after the accepting edge.
    task automatic start_req(input logic [31:0] v, input logic u, input logic [2:0] r,
                             output logic ir1);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL req_wait: in_ready still %b after %0d cycles, required 1", in_ready, n);
        end
        int_val     = v;
        is_unsigned = u;
        rm          = r;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ir1      = in_ready;
    endtask

    // Edges after acceptance until out_valid is seen; 99 on timeout.
    task automatic wait_valid(output int lat);
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic watch_quiet(output logic saw);
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) saw = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vec_cnt++;
        if ({in_ready, out_valid} !== 2'b10) begin
            err_cnt++;
            $display("FAIL reset_hs: got in_ready/out_valid %b, required 10", {in_ready, out_valid});
        end
        vec_cnt++;
        if ({f_result, fflags} !== 37'd0) begin
            err_cnt++;
            $display("FAIL reset_res: got f_result %h fflags %b, required 0", f_result, fflags);
        end
`ifdef FPU_I2F_CLASS_EN
        vec_cnt++;
        if (f_class !== 10'd0) begin
            err_cnt++;
            $display("FAIL reset_class: got %b, required 0", f_class);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_release: got in_ready %b, required 1", in_ready);
        end
    endtask

    task automatic test_convert();
        vec_t        vt[$];
        logic        ir1;
        int          lat;
        logic [9:0]  cls;
        vt.push_back({32'h0000_0001, 1'b0, 3'b000, 32'h3F80_0000, 1'b0, 6'd33});
        vt.push_back({32'hFFFF_FFFF, 1'b0, 3'b000, 32'hBF80_0000, 1'b0, 6'd33});
        vt.push_back({32'h8000_0000, 1'b0, 3'b000, 32'hCF00_0000, 1'b0, 6'd2});
        vt.push_back({32'h0100_0001, 1'b0, 3'b000, 32'h4B80_0000, 1'b1, 6'd9});
        vt.push_back({32'h0100_0001, 1'b0, 3'b011, 32'h4B80_0001, 1'b1, 6'd9});
        vt.push_back({32'h0100_0001, 1'b0, 3'b001, 32'h4B80_0000, 1'b1, 6'd9});
        vt.push_back({32'h0100_0001, 1'b0, 3'b100, 32'h4B80_0001, 1'b1, 6'd9});
        vt.push_back({32'hFFFF_FFFF, 1'b1, 3'b000, 32'h4F80_0000, 1'b1, 6'd2});
        vt.push_back({32'hFFFF_FFFF, 1'b1, 3'b001, 32'h4F7F_FFFF, 1'b1, 6'd2});
        vt.push_back({32'h0000_0000, 1'b0, 3'b000, 32'h0000_0000, 1'b0, 6'd2});
        vt.push_back({32'hFEFF_FFFF, 1'b0, 3'b010, 32'hCB80_0001, 1'b1, 6'd9});
        vt.push_back({32'hFEFF_FFFF, 1'b0, 3'b011, 32'hCB80_0000, 1'b1, 6'd9});
        vt.push_back({32'h0100_0003, 1'b0, 3'b101, 32'h4B80_0002, 1'b1, 6'd9});
        vt.push_back({32'h0100_0003, 1'b0, 3'b010, 32'h4B80_0001, 1'b1, 6'd9});
        vt.push_back({32'h8000_0000, 1'b1, 3'b000, 32'h4F00_0000, 1'b0, 6'd2});
        vt.push_back({32'h0000_0003, 1'b1, 3'b000, 32'h4040_0000, 1'b0, 6'd32});
        vt.push_back({32'h7FFF_FFFF, 1'b0, 3'b000, 32'h4F00_0000, 1'b1, 6'd3});
        foreach (vt[i]) begin
            start_req(vt[i].v, vt[i].u, vt[i].r, ir1);
            vec_cnt++;
            if (ir1 !== 1'b0) begin
                err_cnt++;
                $display("FAIL busy_v%0d: got in_ready %b after accept, required 0", i, ir1);
            end
            wait_valid(lat);
            vec_cnt++;
            if (lat !== int'(vt[i].lat)) begin
                err_cnt++;
                $display("FAIL latency_v%0d: got %0d cycles, required %0d", i, lat, vt[i].lat);
            end
            vec_cnt++;
            if (f_result !== vt[i].e) begin
                err_cnt++;
                $display("FAIL result_v%0d: got %h, required %h", i, f_result, vt[i].e);
            end
            vec_cnt++;
            if (fflags !== {4'b0000, vt[i].nx}) begin
                err_cnt++;
                $display("FAIL fflags_v%0d: got %b, required %b", i, fflags, {4'b0000, vt[i].nx});
            end
            cls = (vt[i].e == 32'd0) ? 10'h010 : (vt[i].e[31] ? 10'h002 : 10'h040);
`ifdef FPU_I2F_CLASS_EN
            vec_cnt++;
            if (f_class !== cls) begin
                err_cnt++;
                $display("FAIL class_v%0d: got %b, required %b", i, f_class, cls);
            end
`endif
            ack();
            vec_cnt++;
            if ({out_valid, in_ready} !== 2'b01) begin
                err_cnt++;
                $display("FAIL handshake_v%0d: got out_valid/in_ready %b, required 01", i, {out_valid, in_ready});
            end
        end
    endtask

    task automatic test_hold();
        logic ir1;
        logic saw;
        int   lat;
        int   bad;
        start_req(32'h7FFF_FFFF, 1'b0, 3'b000, ir1);
        wait_valid(lat);
        vec_cnt++;
        if (lat !== 3) begin
            err_cnt++;
            $display("FAIL hold_latency: got %0d, required 3", lat);
        end
        @(negedge clk);
        int_val  = 32'h0000_0002;
        in_valid = 1'b1;
        bad      = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            vec_cnt++;
            if ({out_valid, in_ready, f_result, fflags} !== {2'b10, 32'h4F00_0000, 5'b00001}) begin
                err_cnt++;
                bad++;
                $display("FAIL hold_stable: got ov/ir %b res %h fl %b, required 10 4f000000 00001",
                         {out_valid, in_ready}, f_result, fflags);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        vec_cnt++;
        if ({out_valid, in_ready} !== 2'b01) begin
            err_cnt++;
            $display("FAIL hold_release: got out_valid/in_ready %b, required 01", {out_valid, in_ready});
        end
        watch_quiet(saw);
        vec_cnt++;
        if (saw !== 1'b0) begin
            err_cnt++;
            $display("FAIL hold_ignored: got out_valid %b from ignored request, required 0", saw);
        end
    endtask

    task automatic test_flush();
        logic ir1;
        logic saw;
        int   lat;
        start_req(32'h0000_0001, 1'b0, 3'b000, ir1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        vec_cnt++;
        if ({out_valid, in_ready} !== 2'b01) begin
            err_cnt++;
            $display("FAIL flush_idle: got out_valid/in_ready %b, required 01", {out_valid, in_ready});
        end
        watch_quiet(saw);
        vec_cnt++;
        if (saw !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_quiet: got out_valid %b after flush, required 0", saw);
        end
        @(negedge clk);
        int_val  = 32'h0000_0005;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL flush_reject: got in_ready %b, required 1", in_ready);
        end
        watch_quiet(saw);
        vec_cnt++;
        if (saw !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_reject_quiet: got out_valid %b, required 0", saw);
        end
        start_req(32'h0100_0001, 1'b0, 3'b011, ir1);
        wait_valid(lat);
        vec_cnt++;
        if ({lat, f_result, fflags} !== {32'd9, 32'h4B80_0001, 5'b00001}) begin
            err_cnt++;
            $display("FAIL flush_next: got lat %0d res %h fl %b, required 9 4b800001 00001", lat, f_result, fflags);
        end
        ack();
    endtask

    task automatic test_midreset();
        logic ir1;
        logic saw;
        int   lat;
        start_req(32'hFFFF_FFFF, 1'b0, 3'b000, ir1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({out_valid, in_ready} !== 2'b01) begin
            err_cnt++;
            $display("FAIL midreset_idle: got out_valid/in_ready %b, required 01", {out_valid, in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet(saw);
        vec_cnt++;
        if (saw !== 1'b0) begin
            err_cnt++;
            $display("FAIL midreset_quiet: got out_valid %b after reset, required 0", saw);
        end
        start_req(32'h0000_0003, 1'b1, 3'b000, ir1);
        wait_valid(lat);
        vec_cnt++;
        if ({lat, f_result, fflags} !== {32'd32, 32'h4040_0000, 5'b00000}) begin
            err_cnt++;
            $display("FAIL midreset_next: got lat %0d res %h fl %b, required 32 40400000 00000", lat, f_result, fflags);
        end
        ack();
    endtask

    initial begin
        flush       = 1'b0;
        in_valid    = 1'b0;
        int_val     = 32'd0;
        is_unsigned = 1'b0;
        rm          = 3'b000;
        out_ready   = 1'b0;
        rst_n       = 1'b0;
        test_reset();
        test_convert();
        test_hold();
        test_flush();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
